pipe_hazard_ctrl: RTL
=====================

# pipe_hazard_ctrl

- Central stall/flush controller for the 5-stage MIPS pipeline.
- Drives the enable and flush controls of the PC and of the IF/ID, ID/EXE, EXE/MEM and MEM/WB registers.
- Detects load-use hazards and squashes wrong-path instructions on a taken branch.
- Freezes the pipeline while the multi-cycle data memory serves the instruction held in EXE/MEM, with a bounded timeout and a stall-cycle performance counter.

## Interface
Parameters:
- DSIZE, 32, datapath width (used only for counter sizing checks).
- ASIZE, 5, register-address width.
- TIMEOUT, 64, max cycles waiting on dmem_ack before error.
- CNT_W, 16, stall-counter width.

Ports:
- clk  in  1  pipeline clock.
- rst_n  in  1  asynchronous, active-low reset.
- id_rs, id_rt  in  ASIZE  source registers of the instruction in ID.
- id_uses_rs, id_uses_rt  in  1  the ID instruction reads rs/rt.
- exe_memtoreg, exe_wen  in  1  ID/EXE register outputs for the instruction in EXE.
- exe_waddr  in  ASIZE  destination of the EXE instruction.
- exe_branch_taken  in  1  EXE resolved a taken branch/jump.
- mem_valid  in  1  EXE/MEM holds a real instruction.
- mem_memtoreg, mem_MemWrite  in  1  EXE/MEM control outputs.
- dmem_ack  in  1  data memory completes the access this cycle.
- dmem_req  out  1  data memory access request.
- pc_en, if_id_en, id_exe_en, exe_mem_en  out  1  register load enables.
- if_id_flush, id_exe_flush, mem_wb_flush  out  1  load a bubble (all control bits 0) on the next edge.
- stall_cnt  out  CNT_W  cycles with pc_en=0, saturating.
- err  out  1  sticky memory-timeout error.

## Operation
- States: RUN, MWAIT, ERR.
- Priority: ERR > MWAIT/memory stall > branch flush > load-use.
- **mem_access**: mem_valid & (mem_memtoreg | mem_MemWrite).
- **RUN**
  - dmem_req = mem_access.
  - If mem_access & !dmem_ack: all four enables 0 and mem_wb_flush=1; next state MWAIT with wait_cnt=1.
  - Otherwise, if exe_branch_taken: if_id_flush=1, id_exe_flush=1, all enables 1.
  - Otherwise, if load-use: pc_en=0, if_id_en=0, id_exe_flush=1, exe_mem_en=1.
    - Load-use condition: exe_memtoreg & exe_wen & exe_waddr!=0 & ((id_uses_rs & id_rs==exe_waddr) | (id_uses_rt & id_rt==exe_waddr)).
  - Otherwise all enables 1 and all flushes 0.
- **MWAIT**
  - dmem_req=1, all enables 0, mem_wb_flush=1, wait_cnt increments.
  - On dmem_ack: this cycle behaves as RUN with the memory condition satisfied (branch and load-use rules apply); next state RUN.
  - If wait_cnt==TIMEOUT and no ack: next state ERR.
- **ERR**
  - dmem_req=0, all enables 0, all flushes 1, err=1.
  - Left only by reset.
- A branch or load-use seen during a memory stall is ignored that cycle. It is re-evaluated on release because the EXE/ID contents are held.
- stall_cnt increments every cycle pc_en=0 and saturates at all-ones. It does not count while in reset.
- Register 0 never causes a hazard.

## Timing
- Controls are combinational from the inputs and the current state and take effect at the next clk edge.
- dmem_ack is sampled in the same cycle as dmem_req (zero-wait memory gives no stall).
- Load-use costs exactly 1 bubble.
- A taken branch costs 2 squashed slots.
- An ack after N wait cycles gives N frozen cycles.
- Timeout: ERR is entered on the edge after TIMEOUT consecutive un-acked cycles. dmem_req stays high through the TIMEOUT-th cycle.
- Reset (rst_n low, asynchronous, including mid-MWAIT):
  - state=RUN, wait_cnt=0, stall_cnt=0, err=0.
  - While low: dmem_req=0, all enables 0, all flushes 1.
  - First cycle after release follows the RUN rules.

## Structure
- The shared package/define file holds DSIZE, ASIZE and the state encoding (RUN=2'd0, MWAIT=2'd1, ERR=2'd2).
- One sub-module, hazard_detect: a purely combinational load-use comparator.
- The FSM, the counters and the output muxing stay in the top module.

## Test plan
- **Load-use**: exe_memtoreg=1, exe_wen=1, exe_waddr=5, id_rs=5, id_uses_rs=1 -> one cycle of pc_en=0, if_id_en=0, id_exe_flush=1; stall_cnt 0->1. The same with exe_waddr=0 -> no stall.
- **Taken branch**: exe_branch_taken=1, no memory access -> if_id_flush=id_exe_flush=1 for 1 cycle, pc_en=1, stall_cnt unchanged.
- **Memory wait**: mem_valid=1, mem_memtoreg=1, dmem_ack low for 3 cycles then high -> dmem_req high 4 cycles, enables 0 and mem_wb_flush=1 for 3 cycles, stall_cnt=3, back to RUN.
- **Priority**: memory stall plus exe_branch_taken=1 -> no flush during the wait; flush asserted in the ack cycle.
- **Timeout**: TIMEOUT=4, ack never asserted -> dmem_req high 4 cycles, then err=1, enables 0, flushes 1 until reset.
- **Reset mid-wait and saturation**: rst_n low in MWAIT -> outputs reach their reset values immediately, state RUN. With CNT_W=4, 20 stall cycles -> stall_cnt=15.

Source files
------------

// File: rtl/pipe_hazard_ctrl_pkg.sv
// Shared constants and FSM encoding for the pipeline stall/flush controller.
package pipe_hazard_ctrl_pkg;

    localparam int DSIZE = 32;
    localparam int ASIZE = 5;

    typedef enum logic [1:0] {
        ST_RUN   = 2'd0,
        ST_MWAIT = 2'd1,
        ST_ERR   = 2'd2
    } state_e;

endpackage

// File: rtl/pipe_hazard_detect.sv
// Combinational load-use comparator: the load in EXE feeds a source operand of ID.
module pipe_hazard_detect #(
    parameter int ASIZE = pipe_hazard_ctrl_pkg::ASIZE
) (
    input  logic [ASIZE-1:0] id_rs,
    input  logic [ASIZE-1:0] id_rt,
    input  logic             id_uses_rs,
    input  logic             id_uses_rt,
    input  logic             exe_memtoreg,
    input  logic             exe_wen,
    input  logic [ASIZE-1:0] exe_waddr,
    output logic             load_use
);

    logic rs_hit_s;
    logic rt_hit_s;
    logic exe_load_s;

    // Register 0 is hardwired, so a load targeting it never creates a dependency.
    always_comb begin
        exe_load_s = exe_memtoreg && exe_wen && (exe_waddr != {ASIZE{1'b0}});
        rs_hit_s   = id_uses_rs && (id_rs == exe_waddr);
        rt_hit_s   = id_uses_rt && (id_rt == exe_waddr);
        load_use   = exe_load_s && (rs_hit_s || rt_hit_s);
    end

endmodule

// File: rtl/pipe_hazard_ctrl.sv
// Central stall/flush controller: memory freeze with timeout, branch squash,
// load-use bubble insertion and a saturating stall-cycle counter.
module pipe_hazard_ctrl #(
    parameter int DSIZE   = pipe_hazard_ctrl_pkg::DSIZE,
    parameter int ASIZE   = pipe_hazard_ctrl_pkg::ASIZE,
    parameter int TIMEOUT = 64,
    parameter int CNT_W   = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [ASIZE-1:0] id_rs,
    input  logic [ASIZE-1:0] id_rt,
    input  logic             id_uses_rs,
    input  logic             id_uses_rt,
    input  logic             exe_memtoreg,
    input  logic             exe_wen,
    input  logic [ASIZE-1:0] exe_waddr,
    input  logic             exe_branch_taken,
    input  logic             mem_valid,
    input  logic             mem_memtoreg,
    input  logic             mem_MemWrite,
    input  logic             dmem_ack,
    output logic             dmem_req,
    output logic             pc_en,
    output logic             if_id_en,
    output logic             id_exe_en,
    output logic             exe_mem_en,
    output logic             if_id_flush,
    output logic             id_exe_flush,
    output logic             mem_wb_flush,
    output logic [CNT_W-1:0] stall_cnt,
    output logic             err
);

    import pipe_hazard_ctrl_pkg::state_e;
    import pipe_hazard_ctrl_pkg::ST_RUN;
    import pipe_hazard_ctrl_pkg::ST_MWAIT;
    import pipe_hazard_ctrl_pkg::ST_ERR;

    localparam int               WAIT_W      = $clog2(TIMEOUT + 1);
    localparam logic [WAIT_W-1:0] WAIT_LAST_C = WAIT_W'(TIMEOUT - 1);
    // A counter wider than the datapath could not be read back by software.
    localparam bit               CNT_OK_C    = (CNT_W >= 1) && (CNT_W <= DSIZE);

    state_e             state_r;
    state_e             next_state_s;
    logic [WAIT_W-1:0]  wait_cnt_r;
    logic [WAIT_W-1:0]  wait_nxt_s;
    logic [CNT_W-1:0]   stall_cnt_r;
    logic               load_use_s;
    logic               mem_access_s;
    logic               apply_rules_s;

    pipe_hazard_detect #(
        .ASIZE (ASIZE)
    ) u_hazard_detect (
        .id_rs        (id_rs),
        .id_rt        (id_rt),
        .id_uses_rs   (id_uses_rs),
        .id_uses_rt   (id_uses_rt),
        .exe_memtoreg (exe_memtoreg),
        .exe_wen      (exe_wen),
        .exe_waddr    (exe_waddr),
        .load_use     (load_use_s)
    );

    // State and wait-cycle registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r    <= ST_RUN;
            wait_cnt_r <= {WAIT_W{1'b0}};
        end else begin
            state_r    <= next_state_s;
            wait_cnt_r <= wait_nxt_s;
        end
    end

    // Next state and pipeline controls; memory freeze outranks branch and load-use.
    always_comb begin
        next_state_s  = state_r;
        wait_nxt_s    = wait_cnt_r;
        mem_access_s  = mem_valid && (mem_memtoreg || mem_MemWrite);
        apply_rules_s = 1'b0;
        dmem_req      = 1'b0;
        pc_en         = 1'b0;
        if_id_en      = 1'b0;
        id_exe_en     = 1'b0;
        exe_mem_en    = 1'b0;
        if_id_flush   = 1'b1;
        id_exe_flush  = 1'b1;
        mem_wb_flush  = 1'b1;

        if (!rst_n) begin
            next_state_s = ST_RUN;
            wait_nxt_s   = {WAIT_W{1'b0}};
        end else begin
            case (state_r)
                ST_RUN: begin
                    dmem_req = mem_access_s;
                    if (mem_access_s && !dmem_ack) begin
                        if_id_flush  = 1'b0;
                        id_exe_flush = 1'b0;
                        next_state_s = (TIMEOUT <= 1) ? ST_ERR : ST_MWAIT;
                        wait_nxt_s   = WAIT_W'(1);
                    end else begin
                        apply_rules_s = 1'b1;
                    end
                end
                ST_MWAIT: begin
                    dmem_req = 1'b1;
                    if (dmem_ack) begin
                        apply_rules_s = 1'b1;
                        next_state_s  = ST_RUN;
                        wait_nxt_s    = {WAIT_W{1'b0}};
                    end else if (wait_cnt_r >= WAIT_LAST_C) begin
                        if_id_flush  = 1'b0;
                        id_exe_flush = 1'b0;
                        next_state_s = ST_ERR;
                    end else begin
                        if_id_flush  = 1'b0;
                        id_exe_flush = 1'b0;
                        wait_nxt_s   = wait_cnt_r + WAIT_W'(1);
                    end
                end
                ST_ERR: begin
                    next_state_s = ST_ERR;
                end
                default: begin
                    next_state_s = ST_ERR;
                end
            endcase
        end

        // Branch/load-use only act once the memory stage is free to advance.
        if (apply_rules_s) begin
            mem_wb_flush = 1'b0;
            exe_mem_en   = 1'b1;
            id_exe_en    = 1'b1;
            if (exe_branch_taken) begin
                pc_en        = 1'b1;
                if_id_en     = 1'b1;
                if_id_flush  = 1'b1;
                id_exe_flush = 1'b1;
            end else if (load_use_s) begin
                pc_en        = 1'b0;
                if_id_en     = 1'b0;
                if_id_flush  = 1'b0;
                id_exe_flush = 1'b1;
            end else begin
                pc_en        = 1'b1;
                if_id_en     = 1'b1;
                if_id_flush  = 1'b0;
                id_exe_flush = 1'b0;
            end
        end else begin
            mem_wb_flush = mem_wb_flush;
        end
    end

    // Saturating count of cycles in which the PC is held.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stall_cnt_r <= {CNT_W{1'b0}};
        end else if (CNT_OK_C && !pc_en && (stall_cnt_r != {CNT_W{1'b1}})) begin
            stall_cnt_r <= stall_cnt_r + CNT_W'(1);
        end else begin
            stall_cnt_r <= stall_cnt_r;
        end
    end

    // Error flag is simply the sticky ERR state.
    always_comb begin
        stall_cnt = stall_cnt_r;
        if (state_r == ST_ERR) begin
            err = 1'b1;
        end else begin
            err = 1'b0;
        end
    end

endmodule
